neo_frame_scheduler: RTL and testbench

Frame-level controller for the NeoPixel serializer. Holds a pixel buffer written by the host and sequences one frame at a time into the serializer over a valid/ready pixel handshake. Inserts the latch (reset) gap after the last pixel, then idles or repeats. Sits between the host register interface and the bit-pattern serializer that drives NEO_DATA.

---
 rtl/neo_frame_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_neo_frame_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neo_frame_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// neo_frame_scheduler: pixel buffer plus frame sequencer feeding the NeoPixel
// serializer, with a latch gap after each frame. Optional macro:
// NEO_DOUBLE_BUFFER_EN (front/back buffers).                       Rev 1.0
// ----------------------------------------------------------------------------
module neo_frame_scheduler #(
    parameter int PIXELS_MAX  = 3,
    parameter int PIXELS_BITS = 2,
    parameter int RESET_DELAY = 600
) (
    input  logic                   CLK_10MHZ,
    input  logic                   RESETN,
    input  logic                   WR_EN,
    input  logic [PIXELS_BITS-1:0] WR_ADDR,
    input  logic [23:0]            WR_DATA,
    output logic                   WR_READY,
    input  logic                   START,
    input  logic                   CONTINUOUS,
    output logic [23:0]            PIX_DATA,
    output logic                   PIX_VALID,
    input  logic                   PIX_READY,
    output logic                   LATCH,
    output logic                   BUSY,
    output logic                   FRAME_DONE
);

    localparam int                     C_GAP_W    = $clog2(RESET_DELAY + 1);
    localparam logic [PIXELS_BITS-1:0] C_LAST_PIX = PIXELS_BITS'(PIXELS_MAX - 1);
    localparam logic [C_GAP_W-1:0]     C_LAST_GAP = C_GAP_W'(RESET_DELAY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [PIXELS_BITS-1:0] pix_idx_q, pix_idx_d;
    logic [C_GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                   start_pend_q, start_pend_d;
    logic [23:0]            pix_data_q, pix_data_d;
    logic                   pix_valid_q, pix_valid_d;
    logic                   frame_done_q, frame_done_d;

    logic [23:0]            w_rd_data;
    logic                   w_addr_ok;
    logic                   w_wr_fire;
    logic                   w_gap_end;

    assign w_addr_ok = (32'(WR_ADDR) < PIXELS_MAX);
    assign w_wr_fire = WR_EN && WR_READY && w_addr_ok;
    assign w_gap_end = (state_q == ST_LATCH) && (gap_cnt_q == C_LAST_GAP);

`ifdef NEO_DOUBLE_BUFFER_EN
    logic        front_sel_q;
    logic        w_front_toggle;
    logic [23:0] buf_q [2][PIXELS_MAX];

    // Only host-requested frames advance to the freshly written buffer.
    assign w_front_toggle = ((state_q == ST_IDLE) && START) ||
                            (w_gap_end && (start_pend_q || START));
    assign WR_READY  = 1'b1;
    assign w_rd_data = buf_q[front_sel_q][pix_idx_q];

    always_ff @(posedge CLK_10MHZ or negedge RESETN) begin
        if (!RESETN) begin
            front_sel_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < PIXELS_MAX; i++) begin
                    buf_q[b][i] <= '0;
                end
            end
        end else begin
            if (w_front_toggle) begin
                front_sel_q <= ~front_sel_q;
            end
            if (w_wr_fire) begin
                buf_q[~front_sel_q][WR_ADDR] <= WR_DATA;
            end
        end
    end
`else
    logic [23:0] buf_q [PIXELS_MAX];

    // The single buffer port is busy reading during FETCH.
    assign WR_READY  = (state_q != ST_FETCH);
    assign w_rd_data = buf_q[pix_idx_q];

    always_ff @(posedge CLK_10MHZ or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < PIXELS_MAX; i++) begin
                buf_q[i] <= '0;
            end
        end else if (w_wr_fire) begin
            buf_q[WR_ADDR] <= WR_DATA;
        end
    end
`endif

    always_ff @(posedge CLK_10MHZ or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= ST_IDLE;
            pix_idx_q    <= '0;
            gap_cnt_q    <= '0;
            start_pend_q <= 1'b0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_idx_q    <= pix_idx_d;
            gap_cnt_q    <= gap_cnt_d;
            start_pend_q <= start_pend_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pix_idx_d    = pix_idx_q;
        gap_cnt_d    = gap_cnt_q;
        start_pend_d = start_pend_q;
        pix_data_d   = pix_data_q;
        pix_valid_d  = pix_valid_q;
        frame_done_d = 1'b0;

        if (START && (state_q != ST_IDLE)) begin
            start_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (START || CONTINUOUS) begin
                    state_d   = ST_FETCH;
                    pix_idx_d = '0;
                end
            end
            ST_FETCH: begin
                pix_data_d  = w_rd_data;
                pix_valid_d = 1'b1;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (PIX_READY) begin
                    pix_valid_d = 1'b0;
                    if (pix_idx_q == C_LAST_PIX) begin
                        state_d   = ST_LATCH;
                        gap_cnt_d = '0;
                    end else begin
                        pix_idx_d = pix_idx_q + 1'b1;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_LATCH: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (w_gap_end) begin
                    // A START landing on the final gap cycle still earns a frame.
                    frame_done_d = 1'b1;
                    start_pend_d = 1'b0;
                    pix_idx_d    = '0;
                    gap_cnt_d    = '0;
                    state_d      = (CONTINUOUS || start_pend_q || START) ? ST_FETCH : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign PIX_DATA   = pix_data_q;
    assign PIX_VALID  = pix_valid_q;
    assign FRAME_DONE = frame_done_q;
    assign LATCH      = (state_q == ST_LATCH);
    assign BUSY       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_neo_frame_scheduler.sv
`default_nettype none
// Testbench for neo_frame_scheduler: directed sequence plus random writes and
// back-pressure, checked against a buffer-level reference model.
module tb_neo_frame_scheduler;

    localparam int PMAX  = 3;
    localparam int PBITS = 2;
    localparam int RD    = 600;
`ifdef NEO_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic             clk       = 1'b0;
    logic             rstn      = 1'b1;
    logic             wr_en     = 1'b0;
    logic [PBITS-1:0] wr_addr   = '0;
    logic [23:0]      wr_data   = '0;
    logic             start     = 1'b0;
    logic             cont      = 1'b0;
    logic             pix_ready = 1'b0;
    logic             WR_READY, PIX_VALID, LATCH, BUSY, FRAME_DONE;
    logic [23:0]      PIX_DATA;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: pixel buffers and which one is shown.
    logic [23:0] mb [2][PMAX];
    int          mfront;

    neo_frame_scheduler #(.PIXELS_MAX(PMAX), .PIXELS_BITS(PBITS), .RESET_DELAY(RD)) dut (
        .CLK_10MHZ (clk),
        .RESETN    (rstn),
        .WR_EN     (wr_en),
        .WR_ADDR   (wr_addr),
        .WR_DATA   (wr_data),
        .WR_READY  (WR_READY),
        .START     (start),
        .CONTINUOUS(cont),
        .PIX_DATA  (PIX_DATA),
        .PIX_VALID (PIX_VALID),
        .PIX_READY (pix_ready),
        .LATCH     (LATCH),
        .BUSY      (BUSY),
        .FRAME_DONE(FRAME_DONE)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int fr();
        return DB ? mfront : 0;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < PMAX; i++) mb[b][i] = '0;
        mfront = 0;
    endtask

    task automatic model_start_trigger();
        if (DB) mfront = 1 - mfront;
    endtask

    task automatic host_write(input logic [PBITS-1:0] a, input logic [23:0] d);
        int n = 0;
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        while (WR_READY !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("wr_ready_timeout", WR_READY, 1);
        @(negedge clk);
        wr_en = 1'b0;
        if (int'(a) < PMAX) mb[DB ? 1 - mfront : 0][a] = d;
    endtask

    task automatic start_frame(output int n0);
        @(negedge clk);
        start = 1'b1;
        n0 = cyc;
        model_start_trigger();
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives PIX_READY, checks pixel order/content, stalls, latch gap and FRAME_DONE.
    task automatic watch_frame(input int stall_pix, input int stall_len, input bit rnd,
                               output int first_v, output int last_hs, output int done_cyc);
        int k = 0, held = 0, guard = 0, lat = 0, lat_first = -1, prev_hs = -1;
        bit seen_v = 1'b0;
        first_v = -1; last_hs = -1; done_cyc = -1;
        pix_ready = 1'b0;
        while (k < PMAX && guard < 4000) begin
            @(negedge clk);
            guard++;
            pix_ready = 1'b0;
            if (PIX_VALID === 1'b1) begin
                if (!seen_v) begin
                    seen_v = 1'b1;
                    if (k == 0) first_v = cyc;
                    else chk("pix_gap", cyc - prev_hs, 2);
                end
                if (k == stall_pix && held < stall_len) begin
                    chk("stall_data", PIX_DATA, mb[fr()][k]);
                    held++;
                end else if (!(rnd && $urandom_range(0, 2) == 0)) begin
                    chk("pix_data", PIX_DATA, mb[fr()][k]);
                    pix_ready = 1'b1;
                    prev_hs = cyc;
                    k++;
                    seen_v = 1'b0;
                end
            end
        end
        last_hs = prev_hs;
        if (k < PMAX) begin
            chk("pix_count", k, PMAX);
            pix_ready = 1'b0;
            return;
        end
        for (int i = 0; i < RD + 8 && done_cyc < 0; i++) begin
            @(negedge clk);
            pix_ready = 1'b0;
            if (LATCH === 1'b1) begin
                lat++;
                if (lat_first < 0) lat_first = cyc;
            end
            if (FRAME_DONE === 1'b1) done_cyc = cyc;
        end
        chk("latch_start", lat_first - last_hs, 1);
        chk("latch_len", lat, RD);
        chk("frame_done_at", done_cyc - last_hs, RD + 1);
    endtask

    initial begin
        int n0, fv, lh, dc, fv2, lh2, dc2, fv3, lh3, dc3;
        logic [23:0] wv;

        model_reset();
        #10 rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", PIX_VALID, 0);
        chk("rst_data", PIX_DATA, 0);
        chk("rst_latch", LATCH, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", FRAME_DONE, 0);
        chk("rst_wr_ready", WR_READY, 1);
        rstn = 1'b1;
        @(negedge clk);

        // Basic frame with the reference colours.
        host_write(2'd0, 24'hff00d5);
        host_write(2'd1, 24'h008800);
        host_write(2'd2, 24'h000090);
        start_frame(n0);
        chk("fetch_busy", BUSY, 1);
        chk("fetch_valid", PIX_VALID, 0);
        chk("fetch_wr_ready", WR_READY, DB ? 1 : 0);
        watch_frame(-1, 0, 1'b0, fv, lh, dc);
        chk("start_to_valid", fv - n0, 2);
        chk("idle_busy", BUSY, 0);
        chk("idle_latch", LATCH, 0);
        @(negedge clk);
        chk("done_one_pulse", FRAME_DONE, 0);

        // Back-pressure on pixel 1 for 10 cycles.
        host_write(2'd0, 24'hff00d5);
        host_write(2'd1, 24'h008800);
        host_write(2'd2, 24'h000090);
        start_frame(n0);
        watch_frame(1, 10, 1'b0, fv, lh, dc);

        // Random contents (including dropped address 3) with random back-pressure.
        for (int f = 0; f < 3; f++) begin
            for (int w = 0; w < 4; w++) host_write(PBITS'($urandom_range(0, 3)), 24'($urandom));
            start_frame(n0);
            watch_frame(-1, 0, 1'b1, fv, lh, dc);
            chk("rand_idle", BUSY, 0);
        end

        // Continuous repeat: three frames, same front buffer.
        @(negedge clk);
        cont = 1'b1;
        n0 = cyc;
        watch_frame(-1, 0, 1'b0, fv, lh, dc);
        chk("cont_start", fv - n0, 2);
        watch_frame(-1, 0, 1'b0, fv2, lh2, dc2);
        cont = 1'b0;
        watch_frame(-1, 0, 1'b0, fv3, lh3, dc3);
        chk("cont_period1", dc2 - dc, 3 * 2 + RD);
        chk("cont_period2", dc3 - dc2, 3 * 2 + RD);
        chk("cont_gap1", fv2 - lh, RD + 2);
        chk("cont_gap2", fv3 - lh2, RD + 2);
        chk("cont_end_idle", BUSY, 0);

        // Extra STARTs during a frame merge into one pending frame.
        @(negedge clk);
        start = 1'b1;
        model_start_trigger();
        repeat (2) @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        watch_frame(-1, 0, 1'b0, fv, lh, dc);
        model_start_trigger();
        chk("pend_busy", BUSY, 1);
        watch_frame(-1, 0, 1'b0, fv, lh, dc);
        chk("pend_end_idle", BUSY, 0);
        repeat (5) @(negedge clk);
        chk("pend_no_third", BUSY, 0);

        // Write held across FETCH, then a follow-up frame.
        wv = 24'($urandom);
        @(negedge clk);
        start = 1'b1;
        model_start_trigger();
        @(negedge clk);
        start   = 1'b0;
        wr_addr = 2'd2;
        wr_data = wv;
        wr_en   = 1'b1;
        chk("wr_stall_fetch", WR_READY, DB ? 1 : 0);
        @(negedge clk);
        chk("wr_ready_send", WR_READY, 1);
        mb[DB ? 1 - mfront : 0][2] = wv;
        @(negedge clk);
        wr_en = 1'b0;
        watch_frame(-1, 0, 1'b0, fv, lh, dc);
        start_frame(n0);
        watch_frame(-1, 0, 1'b0, fv, lh, dc);

        // Reset mid-SEND of pixel 1.
        start_frame(n0);
        @(negedge clk);
        chk("p0_valid", PIX_VALID, 1);
        pix_ready = 1'b1;
        @(negedge clk);
        pix_ready = 1'b0;
        @(negedge clk);
        chk("p1_valid", PIX_VALID, 1);
        chk("p1_data", PIX_DATA, mb[fr()][1]);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", PIX_VALID, 0);
        chk("mid_rst_data", PIX_DATA, 0);
        chk("mid_rst_latch", LATCH, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_wr_ready", WR_READY, 1);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        start_frame(n0);
        watch_frame(-1, 0, 1'b0, fv, lh, dc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
